// File: rtl/matrix_c_stream_out.sv
// Drain buffer for result matrices: captures a row*col matrix of 32-bit words in one
// cycle and streams it out element 0 first, one word per valid/ready handshake.
module matrix_c_stream_out #(
  parameter int row = 4,
  parameter int col = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [row*col*32-1:0]    Data_in,
  output logic [31:0]              Data_out,
  output logic                     Data_valid,
  input  logic                     Data_ready,
  output logic                     Busy,
  output logic                     Done
);

  localparam int N  = row * col;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [N*32-1:0]  shadow;
  logic [IW-1:0]    index, index_nxt;
  logic             capture;
  logic             done_nxt;

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          index_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // load is deliberately not looked at here, so a mid-stream load is dropped
        if (Data_ready) begin
          if (index == IW'(N - 1)) begin
            index_nxt = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            index_nxt = index + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      index  <= '0;
      shadow <= '0;
      Done   <= 1'b0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      Done  <= done_nxt;
      if (capture) begin
        shadow <= Data_in;
      end
    end
  end

  // Outputs decode registered state only; Data_ready/load never reach them combinationally.
  assign Busy       = (state == SEND);
  assign Data_valid = (state == SEND);
  assign Data_out   = (state == SEND) ? shadow[32*int'(index) +: 32] : 32'h0;

endmodule

// File: tb/tb_matrix_c_stream_out.sv
// Bench for matrix_c_stream_out: table-driven streams plus hand sequences, with a
// scoreboard fed on accepted loads and drained on observed handshakes.
module tb_matrix_c_stream_out;

  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int N   = ROW * COL;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [N*32-1:0]   Data_in;
  logic [31:0]       Data_out;
  logic              Data_valid;
  logic              Data_ready;
  logic              Busy;
  logic              Done;

  always #5 clk = ~clk;

  matrix_c_stream_out #(.row(ROW), .col(COL)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .Data_in    (Data_in),
    .Data_out   (Data_out),
    .Data_valid (Data_valid),
    .Data_ready (Data_ready),
    .Busy       (Busy),
    .Done       (Done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard
  logic [31:0] sb[$];
  bit          m_send = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_send = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      sb.delete();
    end else begin
      m_done = 1'b0;
      if (!m_send) begin
        if (load) begin
          for (int k = 0; k < N; k++) sb.push_back(Data_in[k*32 +: 32]);
          m_send = 1'b1;
          m_cnt  = 0;
        end
      end else if (Data_ready) begin
        if (m_cnt == N - 1) begin
          m_send = 1'b0;
          m_cnt  = 0;
          m_done = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  logic [31:0] prev_out   = '0;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {31'b0, Busy}, {31'b0, m_send});
      check("valid", {31'b0, Data_valid}, {31'b0, m_send});
      check("done", {31'b0, Done}, {31'b0, m_done});
      if (!Data_valid) check("idle_out", Data_out, 32'h0);
      if (prev_stall && Data_valid) check("stall_hold", Data_out, prev_out);
      if (Data_valid && Data_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word %h expected none at %0t", Data_out, $time);
        end else begin
          check("data", Data_out, sb.pop_front());
        end
      end
      prev_stall = Data_valid && !Data_ready && !reset;
      prev_out   = Data_out;
    end
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [3:0]  mask;      // Data_ready pattern, bit (c % 4) on stream cycle c
    bit          scramble;  // overwrite Data_in with all ones after capture
    int          exp_len;   // Busy cycles == cycle index of Done
  } vec_t;

  vec_t vecs[5];

  task automatic fill(input logic [31:0] base, input logic [31:0] stride);
    for (int k = 0; k < N; k++) Data_in[k*32 +: 32] = base + 32'(k) * stride;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, output int len, output int done_c);
    fill(v.base, v.stride);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    if (v.scramble) Data_in = '1;
    len    = 0;
    done_c = -1;
    for (int c = 0; c < 300; c++) begin
      Data_ready = v.mask[c % 4];
      @(negedge clk);
      if (Busy) len++;
      if (Done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    Data_ready = 1'b1;
  endtask

  initial begin
    int len, done_c, saw_done;
    vecs[0] = '{32'h1000_0000, 32'h1,         4'b1111, 1'b0, 16};
    vecs[1] = '{32'h1000_0000, 32'h1,         4'b1001, 1'b0, 32};
    vecs[2] = '{32'hA5A5_0000, 32'h0101_0101, 4'b0101, 1'b1, 31};
    vecs[3] = '{32'hFFFF_FFF0, 32'h1,         4'b0111, 1'b1, 21};
    vecs[4] = '{32'h0000_0000, 32'hDEAD_BEEF, 4'b1000, 1'b0, 64};

    // Reset with load and ready asserted must not start a stream
    reset = 1'b1; load = 1'b1; Data_ready = 1'b1;
    fill(32'h1000_0000, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out", Data_out, 32'h0);
    check("rst_valid", {31'b0, Data_valid}, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'b0, Data_valid}, 32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_vec(vecs[i], len, done_c);
      check($sformatf("v%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
      check($sformatf("v%0d_done_at", i), 32'(done_c), 32'(vecs[i].exp_len));
    end

    // Loads during the stream are dropped; a load in the Done cycle is taken
    fill(32'h1000_0000, 32'h1);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    Data_ready = 1'b1;
    done_c = -1;
    for (int c = 0; c < 80; c++) begin
      if (c == 5)  begin fill(32'h2000_0000, 32'h1); load = 1'b1; end
      if (c == 6)  load = 1'b0;
      if (c == 15) load = 1'b1;
      if (c == 17) load = 1'b0;
      @(negedge clk);
      if (c == 5)  check("ld5_out", Data_out, 32'h1000_0005);
      if (c == 15) check("last_out", Data_out, 32'h1000_000F);
      if (c == 16) check("first_done", {31'b0, Done}, 32'h1);
      if (c == 17) begin
        check("restart_busy", {31'b0, Busy}, 32'h1);
        check("restart_out", Data_out, 32'h2000_0000);
      end
      if (Done && c > 16) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("second_done_at", 32'(done_c), 32'd33);
    @(posedge clk); #1;

    // Reset mid-stream aborts with no Done, then a fresh load starts at element 0
    fill(32'h3000_0000, 32'h1);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 7) reset = 1'b1;
      if (c == 8) reset = 1'b0;
      @(negedge clk);
      if (c == 7) check("abort_at", Data_out, 32'h3000_0007);
      if (c == 8) begin
        check("abort_valid", {31'b0, Data_valid}, 32'h0);
        check("abort_busy", {31'b0, Busy}, 32'h0);
      end
      if (Done) saw_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(saw_done), 32'h0);
    run_vec(vecs[0], len, done_c);
    check("after_abort_len", 32'(len), 32'd16);
    check("after_abort_done", 32'(done_c), 32'd16);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_c_stream_out.md
# matrix_c_stream_out

Parallel-to-serial output buffer for result matrices. On a load strobe it captures an entire row×col matrix of 32-bit elements in one cycle, then streams the elements out one 32-bit word per handshake over a valid/ready interface. It is the drain side of the matrix datapath, feeding the result bus that external consumers read word by word.

## Interface
- row, 4, number of matrix rows
- col, 4, number of matrix columns; total words N = row*col (N ≥ 2)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  capture request; honoured only in IDLE
- Data_in  input  row*col*32  packed matrix; element k at bits [(k+1)*32-1 -: 32]
- Data_out  output  32  current element being offered
- Data_valid  output  1  Data_out holds a valid element
- Data_ready  input  1  consumer accepts Data_out this cycle
- Busy  output  1  stream in progress (state SEND)
- Done  output  1  one-cycle pulse after the last element is accepted

## Operation
- Internal storage: shadow register, N×32 bits. Word index counter, $clog2(N) bits.
- States: IDLE, SEND.
- IDLE: Busy=0, Data_valid=0, Data_out=0. When load=1, capture all of Data_in into the shadow register, set index=0, and move to SEND.
- SEND: Busy=1, Data_valid=1, Data_out=shadow[index].
  - A handshake occurs when Data_valid && Data_ready.
  - On a handshake with index<N-1: index increments by 1.
  - On a handshake with index==N-1: move to IDLE, clear index to 0, and assert Done on the next cycle.
- Element order: element 0 (Data_in[31:0]) is sent first and element N-1 last. There is no reordering.
- load while in SEND is ignored. The shadow register stays unchanged and the stream continues. This includes a load in the same cycle as the final handshake; that load is dropped and a new load is required in IDLE.
- Data_in is sampled only in the capture cycle. Later changes to Data_in do not affect the stream.
- Done is registered and high for exactly one cycle, the first IDLE cycle after the final handshake. A load in that cycle is accepted normally.
- Index never exceeds N-1. No wrap-around occurs inside a stream.

## Timing
- Reset values (the cycle after reset is sampled high): state IDLE, index 0, shadow all zero, Data_out=0, Data_valid=0, Busy=0, Done=0.
- Reset has priority over load and handshakes. Reset mid-stream aborts the stream with no Done pulse.
- Load latency: load high in IDLE at edge t gives Data_valid=1, Busy=1 and Data_out=element 0 from t+1.
- Throughput: one element per cycle while Data_ready=1. A full stream with ready held high takes N cycles (t+1..t+N), and Done is high at t+N+1.
- Back-pressure: while Data_valid=1 and Data_ready=0, Data_out and index hold stable with no glitching.
- Data_ready is ignored while Data_valid=0.
- All outputs are registered or decoded from registered state. There is no combinational path from Data_ready or load to any output.

## Test plan
- Reset: assert reset 2 cycles with load=1, Data_ready=1 -> all outputs 0, no stream starts.
- Basic stream: Data_in element k = 32'h1000_0000+k, load 1 cycle, Data_ready=1 -> Data_out 0x10000000..0x1000000F on cycles t+1..t+16, Busy high over the same span, single Done at t+17.
- Back-pressure: same data, Data_ready toggled 1,0,0,1,… -> every element appears exactly once in order, and Data_out is stable during ready=0 cycles.
- Load during stream: second load with different Data_in at element 5 and again in the final-handshake cycle -> stream completes with the original data and no restart. A load in the Done cycle starts a new stream with the new data at the next cycle.
- Input change after capture: change Data_in to all 32'hFFFF_FFFF one cycle after load -> output still carries the captured values.
- Reset mid-stream: reset at element 7 -> the next cycle has Data_valid=0, Busy=0 and Done never asserts. A following load restarts from element 0.
